pipeline_stall_ctrl: RTL and testbench

- Control end of the pipeline-register `enable` inputs.
- Generates the PC enable, the per-stage enables (IF/ID, ID/EX, EX/MEM, MEM/WB), and the IF/ID and ID/EX flushes.
- Sources: load-use hazard detection, taken-branch flush (branches resolve in ID), and a halt-drain FSM that retires the halting instruction through MEM/WB before freezing the core.
- Keeps a saturating load-use stall counter for debug.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 25 ++
 rtl/pipeline_stall_ctrl_load_use_detect.sv | 35 +++
 rtl/pipeline_stall_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_ctrl_pkg
//  Description : Shared constants for the pipeline stall/flush controller:
//                FSM state encoding, drain timeout default, NOP encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_stall_ctrl_pkg;

    // Controller FSM state encoding
    localparam logic [1:0] c_st_run    = 2'b00;
    localparam logic [1:0] c_st_drain  = 2'b01;
    localparam logic [1:0] c_st_halted = 2'b10;

    // Cycles allowed in DRAIN before the halt is forced
    localparam int c_drain_timeout_def = 4;

    // Instruction word loaded into IF/ID when it is flushed
    localparam logic [15:0] c_nop_instr = 16'h0000;

    // Register 0 is hardwired zero and never creates a dependency
    localparam logic [3:0] c_reg_zero = 4'd0;

endpackage : pipeline_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_ctrl_load_use_detect
//  Description : Combinational load-use hazard comparator. Flags an ID
//                instruction that reads the destination of a load in EX.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl_load_use_detect
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic       mem_read_dx,
    input  logic       reg_write_dx,
    input  logic [3:0] write_reg_dx,
    input  logic [3:0] rs_fd,
    input  logic [3:0] rt_fd,
    input  logic       rs_used_fd,
    input  logic       rt_used_fd,
    input  logic       rt_store_data_fd,
    output logic       lu
);

    logic w_load_dst;
    logic w_rs_hit;
    logic w_rt_hit;

    // A store's data operand is forwarded MEM->MEM, so it never needs the bubble
    always_comb begin
        w_load_dst = mem_read_dx & reg_write_dx & (write_reg_dx != c_reg_zero);
        w_rs_hit   = rs_used_fd & (rs_fd == write_reg_dx);
        w_rt_hit   = rt_used_fd & ~rt_store_data_fd & (rt_fd == write_reg_dx);
        lu         = w_load_dst & (w_rs_hit | w_rt_hit);
    end

endmodule : pipeline_stall_ctrl_load_use_detect
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_ctrl
//  Description : Pipeline-register enable/flush generation: load-use stall,
//                taken-branch flush, and halt-drain FSM with timeout. Keeps a
//                saturating count of load-use stall cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = c_drain_timeout_def,
    parameter int CNT_W         = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             hlt_fd,
    input  logic             branch_taken_fd,
    input  logic [3:0]       rs_fd,
    input  logic [3:0]       rt_fd,
    input  logic             rs_used_fd,
    input  logic             rt_used_fd,
    input  logic             rt_store_data_fd,
    input  logic             mem_read_dx,
    input  logic             reg_write_dx,
    input  logic [3:0]       write_reg_dx,
    input  logic             hlt_mw,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             dx_en,
    output logic             dx_flush,
    output logic             xm_en,
    output logic             mw_en,
    output logic             halted,
    output logic             drain_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int                    c_dcnt_w    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [c_dcnt_w-1:0]   c_dcnt_last = c_dcnt_w'(DRAIN_TIMEOUT - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_dcnt_w-1:0] r_drain_cnt;
    logic                r_drain_error;
    logic [CNT_W-1:0]    r_stall_count;
    logic                w_lu;
    logic                w_stall;
    logic                w_drain_done;
    logic                w_pc_en, w_fd_en, w_fd_flush, w_dx_en, w_dx_flush;
    logic                w_xm_en, w_mw_en;

    pipeline_stall_ctrl_load_use_detect u_load_use_detect (
        .mem_read_dx      (mem_read_dx),
        .reg_write_dx     (reg_write_dx),
        .write_reg_dx     (write_reg_dx),
        .rs_fd            (rs_fd),
        .rt_fd            (rt_fd),
        .rs_used_fd       (rs_used_fd),
        .rt_used_fd       (rt_used_fd),
        .rt_store_data_fd (rt_store_data_fd),
        .lu               (w_lu)
    );

    // Stalls only count in RUN; DRAIN never holds a load behind a consumer
    assign w_stall      = (r_state == c_st_run) & w_lu;
    assign w_drain_done = hlt_mw | (r_drain_cnt == c_dcnt_last);

    // Next-state: a stalled HLT is re-evaluated next cycle before draining
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run:    if (!w_lu && hlt_fd) w_state_nxt = c_st_drain;
            c_st_drain:  if (w_drain_done)    w_state_nxt = c_st_halted;
            c_st_halted: w_state_nxt = c_st_halted;
            default:     w_state_nxt = c_st_run;
        endcase
    end

    // State, drain timer, sticky timeout flag and saturating stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_st_run;
            r_drain_cnt   <= '0;
            r_drain_error <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_drain) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
                if (!hlt_mw && (r_drain_cnt == c_dcnt_last))
                    r_drain_error <= 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end
            if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    // Enables and flushes: same-cycle decode of state and hazards, forced
    // inactive while reset is held
    always_comb begin
        w_pc_en    = 1'b0;
        w_fd_en    = 1'b0;
        w_fd_flush = 1'b0;
        w_dx_en    = 1'b0;
        w_dx_flush = 1'b0;
        w_xm_en    = 1'b0;
        w_mw_en    = 1'b0;
        if (rst) begin
            case (r_state)
                c_st_run: begin
                    w_pc_en = 1'b1;
                    w_fd_en = 1'b1;
                    w_dx_en = 1'b1;
                    w_xm_en = 1'b1;
                    w_mw_en = 1'b1;
                    if (w_lu) begin
                        w_pc_en    = 1'b0;
                        w_fd_en    = 1'b0;
                        w_dx_flush = 1'b1;
                    end else if (hlt_fd) begin
                        w_pc_en    = 1'b0;
                        w_fd_flush = 1'b1;
                    end else if (branch_taken_fd) begin
                        w_fd_flush = 1'b1;
                    end
                end
                c_st_drain: begin
                    w_fd_en    = 1'b1;
                    w_fd_flush = 1'b1;
                    w_dx_en    = 1'b1;
                    w_xm_en    = 1'b1;
                    w_mw_en    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pc_en       = w_pc_en;
    assign fd_en       = w_fd_en;
    assign fd_flush    = w_fd_flush;
    assign dx_en       = w_dx_en;
    assign dx_flush    = w_dx_flush;
    assign xm_en       = w_xm_en;
    assign mw_en       = w_mw_en;
    assign halted      = (r_state == c_st_halted);
    assign drain_error = r_drain_error;
    assign stall_count = r_stall_count;

endmodule : pipeline_stall_ctrl
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stall_ctrl
//  Description : Directed self-checking bench for pipeline_stall_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hlt_fd = 1'b0, branch_taken_fd = 1'b0;
    logic [3:0]  rs_fd = '0, rt_fd = '0, write_reg_dx = '0;
    logic        rs_used_fd = 1'b0, rt_used_fd = 1'b0, rt_store_data_fd = 1'b0;
    logic        mem_read_dx = 1'b0, reg_write_dx = 1'b0, hlt_mw = 1'b0;
    logic        pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en;
    logic        halted, drain_error;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    pipeline_stall_ctrl #(.DRAIN_TIMEOUT(4), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .hlt_fd           (hlt_fd),
        .branch_taken_fd  (branch_taken_fd),
        .rs_fd            (rs_fd),
        .rt_fd            (rt_fd),
        .rs_used_fd       (rs_used_fd),
        .rt_used_fd       (rt_used_fd),
        .rt_store_data_fd (rt_store_data_fd),
        .mem_read_dx      (mem_read_dx),
        .reg_write_dx     (reg_write_dx),
        .write_reg_dx     (write_reg_dx),
        .hlt_mw           (hlt_mw),
        .pc_en            (pc_en),
        .fd_en            (fd_en),
        .fd_flush         (fd_flush),
        .dx_en            (dx_en),
        .dx_flush         (dx_flush),
        .xm_en            (xm_en),
        .mw_en            (mw_en),
        .halted           (halted),
        .drain_error      (drain_error),
        .stall_count      (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed {pc,fd,fd_flush,dx,dx_flush,xm,mw}
    function automatic logic [6:0] ctl();
        return {pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en};
    endfunction

    task automatic clear_inputs();
        hlt_fd = 0; branch_taken_fd = 0; rs_fd = 0; rt_fd = 0; write_reg_dx = 0;
        rs_used_fd = 0; rt_used_fd = 0; rt_store_data_fd = 0;
        mem_read_dx = 0; reg_write_dx = 0; hlt_mw = 0;
    endtask

    task automatic set_load(input logic [3:0] dst);
        mem_read_dx = 1; reg_write_dx = 1; write_reg_dx = dst;
    endtask

    initial begin
        // ---- reset held: everything gated off ----
        #1;
        check("rst_ctl",    32'(ctl()),     32'h00);
        check("rst_halted", 32'(halted),    32'h0);
        check("rst_derr",   32'(drain_error), 32'h0);
        check("rst_cnt",    32'(stall_count), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;
        #1 check("run_idle", 32'(ctl()), 32'b1101011);

        // ---- load-use via rs ----
        @(negedge clk) set_load(4'd3); rs_fd = 3; rs_used_fd = 1;
        #1 check("lu_rs_ctl", 32'(ctl()), 32'b0001111);
        @(posedge clk) #1 check("lu_rs_cnt", 32'(stall_count), 32'd1);

        // ---- destination r0: no hazard ----
        @(negedge clk) clear_inputs(); set_load(4'd0); rs_fd = 0; rs_used_fd = 1;
        #1 check("r0_ctl", 32'(ctl()), 32'b1101011);
        @(posedge clk) #1 check("r0_cnt", 32'(stall_count), 32'd1);

        // ---- rt match but store data only: no hazard ----
        @(negedge clk) clear_inputs(); set_load(4'd5); rt_fd = 5; rt_used_fd = 1; rt_store_data_fd = 1;
        #1 check("st_data_ctl", 32'(ctl()), 32'b1101011);
        // ---- same rt match as a real operand: hazard ----
        rt_store_data_fd = 0;
        #1 check("lu_rt_ctl", 32'(ctl()), 32'b0001111);
        @(posedge clk) #1 check("lu_rt_cnt", 32'(stall_count), 32'd2);

        // ---- load-use beats taken branch ----
        @(negedge clk) clear_inputs(); set_load(4'd7); rs_fd = 7; rs_used_fd = 1; branch_taken_fd = 1;
        #1 check("lu_br_ctl", 32'(ctl()), 32'b0001111);
        @(posedge clk) #1 check("lu_br_cnt", 32'(stall_count), 32'd3);
        @(negedge clk) mem_read_dx = 0;
        #1 check("br_ctl", 32'(ctl()), 32'b1111011);

        // ---- load-use beats halt ----
        @(negedge clk) clear_inputs(); set_load(4'd2); rs_fd = 2; rs_used_fd = 1; hlt_fd = 1;
        #1 check("lu_hlt_ctl", 32'(ctl()), 32'b0001111);
        @(posedge clk) #1 check("lu_hlt_stay", 32'(halted), 32'h0);

        // ---- nominal halt; halt beats branch ----
        @(negedge clk) clear_inputs(); hlt_fd = 1; branch_taken_fd = 1;
        #1 check("hlt_ctl", 32'(ctl()), 32'b0111011);
        @(negedge clk) clear_inputs();
        #1 check("drain1_ctl", 32'(ctl()), 32'b0111011);
        // lookalike hazard in DRAIN must not stall
        set_load(4'd4); rs_fd = 4; rs_used_fd = 1;
        #1 check("drain1_nolu", 32'(ctl()), 32'b0111011);
        @(negedge clk) clear_inputs();
        #1 check("drain2_ctl", 32'(ctl()), 32'b0111011);
        check("drain2_halted", 32'(halted), 32'h0);
        @(negedge clk) hlt_mw = 1;
        @(posedge clk) #1;
        check("hlt_halted", 32'(halted), 32'h1);
        check("hlt_ctl_off", 32'(ctl()), 32'h00);
        check("hlt_derr",   32'(drain_error), 32'h0);
        check("hlt_cnt",    32'(stall_count), 32'd4);
        @(negedge clk) clear_inputs(); branch_taken_fd = 1;
        #1 check("halted_sticky", 32'({halted, ctl()}), 32'h80);

        // ---- reset, then drain timeout ----
        @(negedge clk) rst = 0;
        #1 check("rst2_halted", 32'(halted), 32'h0);
        check("rst2_cnt", 32'(stall_count), 32'd0);
        @(negedge clk) rst = 1; clear_inputs(); hlt_fd = 1;
        @(negedge clk) hlt_fd = 0;
        repeat (3) @(posedge clk);
        #1 check("to_not_yet", 32'({halted, drain_error}), 32'h0);
        @(posedge clk) #1;
        check("to_halted", 32'(halted), 32'h1);
        check("to_derr",   32'(drain_error), 32'h1);
        @(negedge clk) rst = 0;
        #1 check("rst3_flags", 32'({halted, drain_error}), 32'h0);
        check("rst3_ctl", 32'(ctl()), 32'h00);
        @(negedge clk) rst = 1;

        // ---- saturation of stall counter ----
        @(negedge clk) clear_inputs(); set_load(4'd9); rs_fd = 9; rs_used_fd = 1;
        repeat (65534) @(posedge clk);
        #1 check("sat_pre", 32'(stall_count), 32'h0000FFFE);
        repeat (7) @(posedge clk);
        #1 check("sat_hold", 32'(stall_count), 32'h0000FFFF);
        check("sat_ctl", 32'(ctl()), 32'b0001111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipeline_stall_ctrl
`default_nettype wire
